// File: rtl/zf_slave_settings_if.sv
`default_nettype none
// ============================================================================
//  Module   : zf_slave_settings_if
//  Purpose  : AXI4-Lite write-channel bundle (AW, W, B) for the control slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface zf_slave_settings_if;
    logic [31:0] AXI_AWADDR;
    logic        AXI_AWVALID;
    logic        AXI_AWREADY;
    logic [31:0] AXI_WDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_WVALID;
    logic        AXI_WREADY;
    logic [1:0]  AXI_BRESP;
    logic        AXI_BVALID;
    logic        AXI_BREADY;

    modport master (
        output AXI_AWADDR, AXI_AWVALID,
        input  AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WVALID,
        input  AXI_WREADY,
        input  AXI_BRESP, AXI_BVALID,
        output AXI_BREADY
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWVALID,
        output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,
        output AXI_WREADY,
        output AXI_BRESP, AXI_BVALID,
        input  AXI_BREADY
    );
endinterface
`default_nettype wire

// File: rtl/zf_slave_settings.sv
`default_nettype none
// ============================================================================
//  Module   : zf_slave_settings
//  Purpose  : AXI4-Lite write slave that turns decoded writes into single-cycle
//             settings-bus strobes for the FIFO configuration registers.
//  Revision : 1.0 - initial release
// ============================================================================
module zf_slave_settings #(
    parameter logic [31:0] CONFIG_BASE = 32'h40000000,
    parameter int          SR_AWIDTH   = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    zf_slave_settings_if.slave        axi,
    output logic                      set_stb,
    output logic [SR_AWIDTH-1:0]      set_addr,
    output logic [31:0]               set_data,
    output logic [31:0]               debug
);

    localparam logic [3:0]  c_STATE_COLLECT = 4'd0;
    localparam logic [3:0]  c_STATE_WRITE   = 4'd1;
    localparam logic [3:0]  c_STATE_RESP    = 4'd2;

    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  c_RESP_DECERR = 2'b11;

    // One bit wider than the offset so very wide windows cannot overflow.
    localparam logic [32:0] c_WINDOW = 33'd4 << SR_AWIDTH;

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic                 r_aw_got;
    logic                 r_w_got;
    logic [31:0]          r_offset;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic [1:0]           r_resp;
    logic [SR_AWIDTH-1:0] r_set_addr;
    logic [31:0]          r_set_data;
    logic [15:0]          r_wr_count;
    logic [7:0]           r_err_count;

    logic                 w_awready;
    logic                 w_wready;
    logic                 w_bvalid;
    logic                 w_set_stb;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_both;
    logic [31:0]          w_aw_offset;
    logic [31:0]          w_offset;
    logic [31:0]          w_wdata;
    logic [3:0]           w_wstrb;
    logic [1:0]           w_code;

    assign w_aw_hs     = axi.AXI_AWVALID && w_awready;
    assign w_w_hs      = axi.AXI_WVALID && w_wready;
    assign w_aw_offset = axi.AXI_AWADDR - CONFIG_BASE;

    // Beats landing this edge are merged with those already held so the
    // response can be decided on the same edge the second beat arrives.
    assign w_offset = w_aw_hs ? w_aw_offset     : r_offset;
    assign w_wdata  = w_w_hs  ? axi.AXI_WDATA   : r_wdata;
    assign w_wstrb  = w_w_hs  ? axi.AXI_WSTRB   : r_wstrb;
    assign w_both   = (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

    always_comb begin
        w_code = c_RESP_OKAY;
        if ({1'b0, w_offset} >= c_WINDOW) begin
            w_code = c_RESP_DECERR;
        end else if ((w_offset[1:0] != 2'b00) || (w_wstrb != 4'hF)) begin
            w_code = c_RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_STATE_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_STATE_COLLECT;
        case (r_state)
            c_STATE_COLLECT: w_next_state = w_both ? c_STATE_WRITE : c_STATE_COLLECT;
            c_STATE_WRITE:   w_next_state = c_STATE_RESP;
            c_STATE_RESP:    w_next_state = axi.AXI_BREADY ? c_STATE_COLLECT : c_STATE_RESP;
            default:         w_next_state = c_STATE_COLLECT;
        endcase
    end

    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        w_set_stb = 1'b0;
        case (r_state)
            c_STATE_COLLECT: begin
                w_awready = !r_aw_got;
                w_wready  = !r_w_got;
            end
            c_STATE_WRITE:   w_set_stb = (r_resp == c_RESP_OKAY);
            c_STATE_RESP:    w_bvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_got    <= 1'b0;
            r_w_got     <= 1'b0;
            r_offset    <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_resp      <= c_RESP_OKAY;
            r_set_addr  <= '0;
            r_set_data  <= 32'd0;
            r_wr_count  <= 16'd0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                c_STATE_COLLECT: begin
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_offset <= w_aw_offset;
                    end
                    if (w_w_hs) begin
                        r_w_got <= 1'b1;
                        r_wdata <= axi.AXI_WDATA;
                        r_wstrb <= axi.AXI_WSTRB;
                    end
                    // Rejected writes leave the settings bus showing the last good write.
                    if (w_both) begin
                        r_resp <= w_code;
                        if (w_code == c_RESP_OKAY) begin
                            r_set_addr <= w_offset[SR_AWIDTH+1:2];
                            r_set_data <= w_wdata;
                        end
                    end
                end
                c_STATE_WRITE: begin
                    if (r_resp == c_RESP_OKAY) begin
                        r_wr_count <= r_wr_count + 16'd1;
                    end else if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                c_STATE_RESP: begin
                    if (axi.AXI_BREADY) begin
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                    end
                end
                default: begin
                    r_aw_got <= 1'b0;
                    r_w_got  <= 1'b0;
                end
            endcase
        end
    end

    assign axi.AXI_AWREADY = w_awready;
    assign axi.AXI_WREADY  = w_wready;
    assign axi.AXI_BVALID  = w_bvalid;
    assign axi.AXI_BRESP   = w_bvalid ? r_resp : c_RESP_OKAY;

    assign set_stb  = w_set_stb;
    assign set_addr = r_set_addr;
    assign set_data = r_set_data;
    assign debug    = {r_wr_count, r_err_count, 2'b00, r_w_got, r_aw_got, r_state};

endmodule
`default_nettype wire

// File: tb/tb_zf_slave_settings.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zf_slave_settings
//  Purpose  : Self-checking bench for the AXI4-Lite settings write slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zf_slave_settings;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] debug;

    always #5 clk = ~clk;

    zf_slave_settings_if bus ();

    zf_slave_settings #(
        .CONFIG_BASE (32'h40000000),
        .SR_AWIDTH   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi      (bus.slave),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .debug    (debug)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        logic [1:0]  resp;
        logic [7:0]  idx;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic        stb;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [15:0] wr;
        logic [7:0]  err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        vecs[8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          stb_cnt = 0;
    int          bp_aw_w = 0;
    int          bp_w_w = 0;
    logic [7:0]  m_addr = 8'd0;
    logic [31:0] m_data = 32'd0;
    logic [15:0] m_wr = 16'd0;
    logic [7:0]  m_err = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] resp, input logic [7:0] idx, input logic [31:0] data);
        exp_t e;
        if (resp == 2'b00) begin
            m_addr = idx;
            m_data = data;
            m_wr   = m_wr + 16'd1;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
        e.resp = resp;
        e.stb  = (resp == 2'b00);
        e.addr = m_addr;
        e.data = m_data;
        e.wr   = m_wr;
        e.err  = m_err;
        sbq.push_back(e);
    endtask

    // Retirement monitor: each B handshake pops one expected write.
    always @(negedge clk) begin
        if (!rst_n) begin
            stb_cnt = 0;
        end else begin
            if (set_stb) stb_cnt++;
            if (!bus.AXI_BVALID) begin
                check("bresp_idle", {30'd0, bus.AXI_BRESP}, 32'd0);
            end else if (bus.AXI_BREADY) begin
                if (sbq.size() == 0) begin
                    check("unexpected_b", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("bresp",     {30'd0, bus.AXI_BRESP}, {30'd0, mon_e.resp});
                    check("stb_count", stb_cnt, {31'd0, mon_e.stb});
                    check("set_addr",  {24'd0, set_addr}, {24'd0, mon_e.addr});
                    check("set_data",  set_data, mon_e.data);
                    check("wr_count",  {16'd0, debug[31:16]}, {16'd0, mon_e.wr});
                    check("err_count", {24'd0, debug[15:8]}, {24'd0, mon_e.err});
                end
                stb_cnt = 0;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input int d, output int waits);
        waits = 0;
        repeat (d) @(posedge clk);
        #1;
        bus.AXI_AWADDR  = a;
        bus.AXI_AWVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.AXI_AWREADY) begin
                @(posedge clk);
                #1 bus.AXI_AWVALID = 1'b0;
                return;
            end
            waits++;
        end
        check("aw_timeout", 32'd1, 32'd0);
        bus.AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] dat, input logic [3:0] s, input int d, output int waits);
        waits = 0;
        repeat (d) @(posedge clk);
        #1;
        bus.AXI_WDATA  = dat;
        bus.AXI_WSTRB  = s;
        bus.AXI_WVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.AXI_WREADY) begin
                @(posedge clk);
                #1 bus.AXI_WVALID = 1'b0;
                return;
            end
            waits++;
        end
        check("w_timeout", 32'd1, 32'd0);
        bus.AXI_WVALID = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", sbq.size(), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int aw_w;
        int w_w;
        push_exp(v.resp, v.idx, v.data);
        fork
            send_aw(v.addr, v.aw_d, aw_w);
            send_w(v.data, v.strb, v.w_d, w_w);
        join
        check("aw_stall", aw_w, 32'd0);
        check("w_stall",  w_w,  32'd0);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h400003FC, 32'h12345678, 4'hF, 3, 0, 2'b00, 8'd255};
        vecs[1] = '{32'h40000400, 32'hAAAA0001, 4'hF, 0, 0, 2'b11, 8'd0};
        vecs[2] = '{32'h3FFFFFFC, 32'hBBBB0002, 4'hF, 0, 0, 2'b11, 8'd0};
        vecs[3] = '{32'h40000002, 32'hCCCC0003, 4'hF, 0, 0, 2'b10, 8'd0};
        vecs[4] = '{32'h40000020, 32'hDDDD0004, 4'h3, 0, 0, 2'b10, 8'd0};
        vecs[5] = '{32'h40000404, 32'hEEEE0005, 4'h3, 1, 0, 2'b11, 8'd0};
        vecs[6] = '{32'h40000000, 32'h0BADF00D, 4'hF, 0, 2, 2'b00, 8'd0};
        vecs[7] = '{32'h40000084, 32'hCAFEF00D, 4'hF, 1, 1, 2'b00, 8'd33};

        bus.AXI_AWADDR  = 32'd0;
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WDATA   = 32'd0;
        bus.AXI_WSTRB   = 4'd0;
        bus.AXI_WVALID  = 1'b0;
        bus.AXI_BREADY  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_awready", {31'd0, bus.AXI_AWREADY}, 32'd1);
        check("rst_wready",  {31'd0, bus.AXI_WREADY},  32'd1);
        check("rst_bvalid",  {31'd0, bus.AXI_BVALID},  32'd0);
        check("rst_set_stb", {31'd0, set_stb}, 32'd0);
        check("rst_set_addr", {24'd0, set_addr}, 32'd0);
        check("rst_set_data", set_data, 32'd0);
        check("rst_debug", debug, 32'd0);
        @(posedge clk);
        #1;

        // Same-cycle AW and W: strobe one cycle after the edge, BVALID the next.
        push_exp(2'b00, 8'd4, 32'hDEADBEEF);
        bus.AXI_AWADDR  = 32'h40000010;
        bus.AXI_AWVALID = 1'b1;
        bus.AXI_WDATA   = 32'hDEADBEEF;
        bus.AXI_WSTRB   = 4'hF;
        bus.AXI_WVALID  = 1'b1;
        @(posedge clk);
        #1;
        bus.AXI_AWVALID = 1'b0;
        bus.AXI_WVALID  = 1'b0;
        @(negedge clk);
        check("lat_stb_hi",    {31'd0, set_stb}, 32'd1);
        check("lat_bvalid_lo", {31'd0, bus.AXI_BVALID}, 32'd0);
        check("lat_addr",      {24'd0, set_addr}, 32'd4);
        check("lat_data",      set_data, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_stb_lo",    {31'd0, set_stb}, 32'd0);
        check("lat_bvalid_hi", {31'd0, bus.AXI_BVALID}, 32'd1);
        wait_drain();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-pressure: SLVERR response held while a second write waits.
        bus.AXI_BREADY = 1'b0;
        push_exp(2'b10, 8'd0, 32'h11111111);
        fork
            send_aw(32'h40000008, 0, bp_aw_w);
            send_w(32'h11111111, 4'h1, 0, bp_w_w);
        join
        for (int i = 0; i < 10 && !bus.AXI_BVALID; i++) @(negedge clk);
        push_exp(2'b00, 8'd3, 32'h22222222);
        fork
            send_aw(32'h4000000C, 0, bp_aw_w);
            send_w(32'h22222222, 4'hF, 0, bp_w_w);
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid",  {31'd0, bus.AXI_BVALID}, 32'd1);
            check("bp_bresp",   {30'd0, bus.AXI_BRESP}, 32'd2);
            check("bp_awready", {31'd0, bus.AXI_AWREADY}, 32'd0);
            check("bp_wready",  {31'd0, bus.AXI_WREADY}, 32'd0);
        end
        @(posedge clk);
        #1 bus.AXI_BREADY = 1'b1;
        wait fork;
        check("bp_aw_held", {31'd0, (bp_aw_w >= 5)}, 32'd1);
        check("bp_w_held",  {31'd0, (bp_w_w >= 5)}, 32'd1);
        wait_drain();

        // Reset during the write cycle drops the strobe and the transaction.
        push_exp(2'b00, 8'd5, 32'h55555555);
        fork
            send_aw(32'h40000014, 0, bp_aw_w);
            send_w(32'h55555555, 4'hF, 0, bp_w_w);
        join
        check("mid_stb_hi", {31'd0, set_stb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_stb_lo",  {31'd0, set_stb}, 32'd0);
        check("mid_bvalid",  {31'd0, bus.AXI_BVALID}, 32'd0);
        check("mid_debug",   debug, 32'd0);
        check("mid_awready", {31'd0, bus.AXI_AWREADY}, 32'd1);
        sbq.delete();
        m_addr = 8'd0;
        m_data = 32'd0;
        m_wr   = 16'd0;
        m_err  = 8'd0;
        repeat (2) @(negedge clk);
        check("mid_no_b", {31'd0, bus.AXI_BVALID}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec('{32'h40000100, 32'h66666666, 4'hF, 0, 0, 2'b00, 8'd64});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
